// File: rtl/cdb_arbiter_if.sv
// Bundles the functional-unit request side and the two-slot CDB broadcast side
// of the result-bus arbiter into one port.
interface cdb_arbiter_if #(
    parameter int N      = 4,
    parameter int ROB_W  = 6,
    parameter int DATA_W = 32
);
    logic [N-1:0]        req;
    logic [N*ROB_W-1:0]  reqRob;
    logic [N*DATA_W-1:0] reqData;
    logic                flush;
    logic [N-1:0]        grant;
    logic                CDBiscast;
    logic [ROB_W-1:0]    CDBrobNum;
    logic [DATA_W-1:0]   CDBdata;
    logic                CDBiscast2;
    logic [ROB_W-1:0]    CDBrobNum2;
    logic [DATA_W-1:0]   CDBdata2;
    logic                badReq;

    modport slave (
        input  req, reqRob, reqData, flush,
        output grant, CDBiscast, CDBrobNum, CDBdata,
               CDBiscast2, CDBrobNum2, CDBdata2, badReq
    );

    modport master (
        output req, reqRob, reqData, flush,
        input  grant, CDBiscast, CDBrobNum, CDBdata,
               CDBiscast2, CDBrobNum2, CDBdata2, badReq
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-slot common-data-bus arbiter: round-robin selection of up to two finished
// results per cycle with distinct ROB tags, broadcast one cycle after grant.
module cdb_arbiter #(
    parameter logic [5:0] INVALID_ROB = 6'b111111
) (
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int N      = 4;
    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    logic [ROB_W-1:0]  tag   [N];
    logic [DATA_W-1:0] dat   [N];
    logic [N-1:0]      elig;
    logic [N-1:0]      bad_vec;

    logic              s1_found, s2_found;
    logic [1:0]        s1_idx, s2_idx;
    logic [1:0]        idx;
    logic [N-1:0]      grant;

    logic [1:0]        ptr_q, ptr_d;
    logic              iscast_q, iscast_d;
    logic [ROB_W-1:0]  rob_q, rob_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              iscast2_q, iscast2_d;
    logic [ROB_W-1:0]  rob2_q, rob2_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic              badreq_q, badreq_d;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            tag[i]     = bus.reqRob[i*ROB_W +: ROB_W];
            dat[i]     = bus.reqData[i*DATA_W +: DATA_W];
            bad_vec[i] = bus.req[i] && (tag[i] == INVALID_ROB);
            elig[i]    = bus.req[i] && (tag[i] != INVALID_ROB) && !bus.flush && !reset;
        end
    end

    // Walk the units starting at ptr; slot 2 must not repeat the slot-1 tag.
    always_comb begin
        s1_found = 1'b0;
        s1_idx   = 2'd0;
        s2_found = 1'b0;
        s2_idx   = 2'd0;
        idx      = 2'd0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + 2'(k);
            if (elig[idx]) begin
                if (!s1_found) begin
                    s1_found = 1'b1;
                    s1_idx   = idx;
                end else if (!s2_found && (tag[idx] != tag[s1_idx])) begin
                    s2_found = 1'b1;
                    s2_idx   = idx;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (s1_found) grant[s1_idx] = 1'b1;
        if (s2_found) grant[s2_idx] = 1'b1;

        ptr_d = ptr_q;
        if (s2_found)      ptr_d = s2_idx + 2'd1;
        else if (s1_found) ptr_d = s1_idx + 2'd1;

        iscast_d  = s1_found;
        rob_d     = s1_found ? tag[s1_idx] : INVALID_ROB;
        data_d    = s1_found ? dat[s1_idx] : '0;
        iscast2_d = s2_found;
        rob2_d    = s2_found ? tag[s2_idx] : INVALID_ROB;
        data2_d   = s2_found ? dat[s2_idx] : '0;

        badreq_d  = badreq_q | (|bad_vec);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q     <= 2'd0;
            iscast_q  <= 1'b0;
            rob_q     <= INVALID_ROB;
            data_q    <= '0;
            iscast2_q <= 1'b0;
            rob2_q    <= INVALID_ROB;
            data2_q   <= '0;
            badreq_q  <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            iscast_q  <= iscast_d;
            rob_q     <= rob_d;
            data_q    <= data_d;
            iscast2_q <= iscast2_d;
            rob2_q    <= rob2_d;
            data2_q   <= data2_d;
            badreq_q  <= badreq_d;
        end
    end

    assign bus.grant      = grant;
    assign bus.CDBiscast  = iscast_q;
    assign bus.CDBrobNum  = rob_q;
    assign bus.CDBdata    = data_q;
    assign bus.CDBiscast2 = iscast2_q;
    assign bus.CDBrobNum2 = rob2_q;
    assign bus.CDBdata2   = data2_q;
    assign bus.badReq     = badreq_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued when a request
// pattern is driven and compared after the following clock edge.
module tb_cdb_arbiter;
    logic clk;
    logic rst;

    cdb_arbiter_if bus();

    cdb_arbiter #(.INVALID_ROB(6'b111111)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        ic;
        logic [5:0]  rob;
        logic [31:0] data;
        logic        ic2;
        logic [5:0]  rob2;
        logic [31:0] data2;
    } slot_t;

    slot_t       sb [$];
    logic [5:0]  t [4];
    logic [31:0] d [4];
    logic        exp_bad;
    int          checks;
    int          errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic f, input logic rs,
                        input int s1, input int s2);
        slot_t      e;
        logic [3:0] g;
        bus.req     = r;
        bus.flush   = f;
        rst         = rs;
        bus.reqRob  = {t[3], t[2], t[1], t[0]};
        bus.reqData = {d[3], d[2], d[1], d[0]};
        #1;
        g = 4'b0000;
        e.ic = 1'b0; e.rob = 6'h3F; e.data = 32'h0;
        e.ic2 = 1'b0; e.rob2 = 6'h3F; e.data2 = 32'h0;
        if (s1 >= 0) begin
            g[s1] = 1'b1; e.ic = 1'b1; e.rob = t[s1]; e.data = d[s1];
        end
        if (s2 >= 0) begin
            g[s2] = 1'b1; e.ic2 = 1'b1; e.rob2 = t[s2]; e.data2 = d[s2];
        end
        chk("grant", {28'h0, bus.grant}, {28'h0, g});
        sb.push_back(e);
        if (rs) exp_bad = 1'b0;
        else for (int i = 0; i < 4; i++) if (r[i] && t[i] == 6'h3F) exp_bad = 1'b1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("CDBiscast",  {31'h0, bus.CDBiscast},  {31'h0, e.ic});
        chk("CDBrobNum",  {26'h0, bus.CDBrobNum},  {26'h0, e.rob});
        chk("CDBdata",    bus.CDBdata,             e.data);
        chk("CDBiscast2", {31'h0, bus.CDBiscast2}, {31'h0, e.ic2});
        chk("CDBrobNum2", {26'h0, bus.CDBrobNum2}, {26'h0, e.rob2});
        chk("CDBdata2",   bus.CDBdata2,            e.data2);
        chk("badReq",     {31'h0, bus.badReq},     {31'h0, exp_bad});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t[i] = 6'(i + 1);
            d[i] = 32'h0;
        end

        // reset
        step(4'b0000, 1'b0, 1'b1, -1, -1);
        step(4'b0000, 1'b0, 1'b1, -1, -1);

        // single request, ptr 0 -> 1
        t[0] = 6'd5; d[0] = 32'h10;
        step(4'b0001, 1'b0, 1'b0, 0, -1);
        step(4'b0000, 1'b0, 1'b0, -1, -1);

        // reset while a two-unit grant would occur; nothing broadcast, ptr -> 0
        t[0] = 6'd1; t[1] = 6'd2; d[0] = 32'hAA00; d[1] = 32'hAA01;
        step(4'b0011, 1'b0, 1'b1, -1, -1);

        // full rotation with all four units requesting
        t[0] = 6'd1; t[1] = 6'd2; t[2] = 6'd3; t[3] = 6'd4;
        d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2; d[3] = 32'hA3;
        step(4'b1111, 1'b0, 1'b0, 0, 1);
        d[0] = 32'hB0; d[1] = 32'hB1;
        step(4'b1111, 1'b0, 1'b0, 2, 3);
        d[2] = 32'hB2; d[3] = 32'hB3;
        step(4'b1111, 1'b0, 1'b0, 0, 1);

        // same tag on two units: only one per cycle (ptr 2)
        t[0] = 6'd7; t[1] = 6'd7; d[0] = 32'hC0; d[1] = 32'hC1;
        step(4'b0011, 1'b0, 1'b0, 0, -1);
        step(4'b0010, 1'b0, 1'b0, 1, -1);

        // flush suppresses grants, ptr holds at 2
        t[1] = 6'd8; t[3] = 6'd9; d[1] = 32'hD1; d[3] = 32'hD3;
        step(4'b1010, 1'b1, 1'b0, -1, -1);
        step(4'b1010, 1'b0, 1'b0, 3, 1);

        // duplicate of slot-1 tag skipped, a later distinct tag fills slot 2
        t[0] = 6'd11; t[2] = 6'd10; t[3] = 6'd10;
        d[0] = 32'hE0; d[2] = 32'hE2; d[3] = 32'hE3;
        step(4'b1101, 1'b0, 1'b0, 2, 0);

        // invalid tag: never granted, sticky badReq (ptr 1)
        t[2] = 6'h3F; d[2] = 32'hF2;
        step(4'b0100, 1'b0, 1'b0, -1, -1);
        step(4'b0000, 1'b0, 1'b0, -1, -1);
        t[1] = 6'd12; d[1] = 32'hF1;
        step(4'b0110, 1'b0, 1'b0, 1, -1);
        step(4'b0000, 1'b0, 1'b1, -1, -1);

        // badReq still updates under flush
        step(4'b0100, 1'b1, 1'b0, -1, -1);

        // ptr is 0 after the reset
        t[0] = 6'd1; t[1] = 6'd2; t[2] = 6'd3; t[3] = 6'd4;
        d[0] = 32'h50; d[1] = 32'h51; d[2] = 32'h52; d[3] = 32'h53;
        step(4'b1111, 1'b0, 1'b0, 0, 1);
        step(4'b0000, 1'b0, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter INVALID_ROB, default 6'b111111, is the ROB tag meaning "no tag"; it is never broadcast as a valid result.
REQ-002 clock  input  1  system clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 req  input  4  req[i]=1: functional unit i holds a finished result awaiting broadcast.
REQ-005 reqRob  input  24  ROB tag of unit i at bits [6i+5:6i].
REQ-006 reqData  input  128  result of unit i at bits [32i+31:32i].
REQ-007 flush  input  1  mispredict flush; suppresses all grants this cycle.
REQ-008 grant  output  4  grant[i]=1: unit i's result is accepted this cycle (combinational).
REQ-009 CDBiscast  output  1  CDB slot 1 carries a valid result (registered).
REQ-010 CDBrobNum  output  6  slot 1 ROB tag.
REQ-011 CDBdata  output  32  slot 1 data.
REQ-012 CDBiscast2  output  1  CDB slot 2 carries a valid result (registered).
REQ-013 CDBrobNum2  output  6  slot 2 ROB tag.
REQ-014 CDBdata2  output  32  slot 2 data.
REQ-015 badReq  output  1  sticky error: some req[i] was asserted with tag INVALID_ROB.

Function
REQ-016 Unit i is eligible when req[i]=1, its tag is not INVALID_ROB, and flush=0.
REQ-017 A 2-bit round-robin pointer ptr sets the search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-018 The first eligible unit in search order wins slot 1; the next eligible unit whose tag differs from the slot-1 tag wins slot 2.
REQ-019 An eligible unit whose tag equals the slot-1 winner's tag is not granted that cycle and keeps waiting.
REQ-020 grant has at most two bits set, exactly one per filled slot, and is valid in the same cycle as req.
REQ-021 A granted unit deasserts req, or presents a new result, on the next edge; an ungranted unit holds req, tag and data stable.
REQ-022 At the edge ending grant cycle T, the winners' tag and data register onto the slot outputs, so the broadcast is visible in cycle T+1 (latency 1).
REQ-023 CDBiscast / CDBiscast2 are one-cycle pulses per grant; an empty slot drives iscast=0, robNum=INVALID_ROB, data=0.
REQ-024 CDBiscast2=1 never occurs while CDBiscast=0.
REQ-025 After any cycle with at least one grant, ptr <= (index of the last granted unit + 1) mod 4; with no grant, ptr holds.
REQ-026 With flush=1: grant=0, both slots are driven empty at the next edge, ptr holds, and badReq still updates.
REQ-027 badReq is set at the edge after any req[i]=1 with tag INVALID_ROB; that unit is never granted; badReq clears only on reset.
REQ-028 Back-to-back requests receive a grant every cycle; the 4-unit rotation guarantees every eligible unit a grant within 2 cycles.

Reset
REQ-029 With reset=1 at an edge: ptr=0, CDBiscast=CDBiscast2=0, CDBrobNum=CDBrobNum2=INVALID_ROB, CDBdata=CDBdata2=0, badReq=0.
REQ-030 While reset=1, grant=0; results granted in the cycle reset asserts are discarded and are not broadcast.

Verification
REQ-031 After reset, req=4'b0001, tag0=5, data0=32'h10 -> grant=0001; next cycle CDBiscast=1, CDBrobNum=5, CDBdata=32'h10, CDBiscast2=0.
REQ-032 ptr=0, req=4'b1111, tags 1,2,3,4 held -> cycle 1 grants units 0,1 (slots: 1,2); cycle 2 grants 2,3; cycle 3 grants 0,1 again.
REQ-033 req=4'b0011, both tags=7 -> grant=0001; next cycle grant=0010; never two slots both tagged 7 in one cycle.
REQ-034 req=4'b0100 with tag 6'b111111 -> grant=0000, badReq=1 next cycle and held until reset.
REQ-035 req=4'b1010 with flush=1 -> grant=0000, both slots empty next cycle; flush=0 next cycle -> units 1,3 granted.
REQ-036 reset asserted in the same cycle as grant=0011 -> outputs at reset values next cycle; nothing broadcast; ptr=0.
